// File: rtl/ccip_tx_flow_scheduler.sv
// ccip_tx_flow_scheduler: round-robin batch scheduler that drains CCI-P TX flow FIFOs one full batch at a time
module ccip_tx_flow_scheduler #(
  parameter int LMAX_NUM_OF_FLOWS = 1,
  parameter int LTX_FIFO_DEPTH = 3,
  parameter int LMAX_CCIP_BATCH = 2,
  parameter int ALMFULL_HOLDOFF = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic [LMAX_NUM_OF_FLOWS-1:0] number_of_flows,
  input  logic [LMAX_CCIP_BATCH-1:0] l_tx_batch_size,
  input  logic [(2**LMAX_NUM_OF_FLOWS)*LTX_FIFO_DEPTH-1:0] flow_dw,
  input  logic sRx_c1TxAlmFull,
  output logic [2**LMAX_NUM_OF_FLOWS-1:0] pop_en,
  output logic sched_valid,
  output logic sched_sop,
  output logic [LMAX_NUM_OF_FLOWS-1:0] sched_flow_id,
  output logic busy,
  output logic cfg_error,
  output logic [31:0] grant_cnt,
  output logic [31:0] stall_cnt
);
  localparam int L = LMAX_NUM_OF_FLOWS;
  localparam int N = 2**L;
  localparam int D = LTX_FIFO_DEPTH;
  localparam int BW = D > 3 ? D : 3;
  localparam int HW = $clog2(ALMFULL_HOLDOFF + 1);
  typedef enum logic [1:0] {SchIdle, SchIssue, SchGap, SchHold} state_t;
  state_t state;
  logic [BW-1:0] batch, batch_q, beat;
  logic [N-1:0] elig;
  logic [L-1:0] rr_ptr, rr_eff, win, nof_q;
  logic [HW-1:0] hcnt;
  logic any_elig;
  assign batch = l_tx_batch_size == '0 ? BW'(1) : l_tx_batch_size == LMAX_CCIP_BATCH'(1) ? BW'(2) : BW'(4);
  for (genvar i = 0; i < N; i++) begin : g_elig
    assign elig[i] = (i <= int'(number_of_flows)) && (BW'(flow_dw[i*D +: D]) >= batch);
  end
  assign any_elig = |elig;
  assign rr_eff = rr_ptr > number_of_flows ? '0 : rr_ptr;
  // rotating priority: lowest eligible at/after rr_eff, otherwise lowest eligible overall (wrap)
  always_comb begin
    win = '0;
    for (int i = N - 1; i >= 0; i--) if (elig[i]) win = L'(i);
    for (int i = N - 1; i >= 0; i--) if (elig[i] && i >= int'(rr_eff)) win = L'(i);
  end
  // scheduler FSM with registered pop/valid/status outputs and saturating counters
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= SchIdle;
      pop_en <= '0;
      sched_valid <= 1'b0;
      sched_sop <= 1'b0;
      sched_flow_id <= '0;
      busy <= 1'b0;
      cfg_error <= 1'b0;
      grant_cnt <= '0;
      stall_cnt <= '0;
      rr_ptr <= '0;
      nof_q <= '0;
      batch_q <= '0;
      beat <= '0;
      hcnt <= '0;
    end else begin
      if (l_tx_batch_size == LMAX_CCIP_BATCH'(3)) cfg_error <= 1'b1;
      case (state)
        SchIdle: begin
          if (sRx_c1TxAlmFull) begin
            state <= SchHold;
            busy <= 1'b1;
            hcnt <= '0;
          end else if (start && any_elig) begin
            state <= batch == BW'(1) ? SchGap : SchIssue;
            pop_en <= N'(1) << win;
            sched_valid <= 1'b1;
            sched_sop <= 1'b1;
            sched_flow_id <= win;
            busy <= 1'b1;
            beat <= BW'(1);
            batch_q <= batch;
            nof_q <= number_of_flows;
            grant_cnt <= &grant_cnt ? grant_cnt : grant_cnt + 32'd1;
          end
        end
        SchIssue: begin
          sched_sop <= 1'b0;
          beat <= beat + BW'(1);
          if (beat + BW'(1) == batch_q) state <= SchGap;
        end
        SchGap: begin
          state <= SchIdle;
          pop_en <= '0;
          sched_valid <= 1'b0;
          sched_sop <= 1'b0;
          busy <= 1'b0;
          rr_ptr <= sched_flow_id == nof_q ? '0 : sched_flow_id + L'(1);
        end
        SchHold: begin
          if (any_elig) stall_cnt <= &stall_cnt ? stall_cnt : stall_cnt + 32'd1;
          if (sRx_c1TxAlmFull) hcnt <= '0;
          else if (hcnt == HW'(ALMFULL_HOLDOFF - 1)) begin
            state <= SchIdle;
            busy <= 1'b0;
            hcnt <= '0;
          end else hcnt <= hcnt + HW'(1);
        end
        default: state <= SchIdle;
      endcase
    end
  end
endmodule

// File: tb/tb_ccip_tx_flow_scheduler.sv
// tb_ccip_tx_flow_scheduler: directed and random checks of the TX flow scheduler against a transaction-level model
module tb_ccip_tx_flow_scheduler;
  localparam int L = 2;
  localparam int N = 4;
  localparam int D = 3;
  localparam int LB = 2;
  localparam int HO = 2;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic start = 1'b0;
  logic [L-1:0] nof = '0;
  logic [LB-1:0] bsz = '0;
  logic [N*D-1:0] flow_dw = '0;
  logic alm = 1'b0;
  logic [N-1:0] pop_en;
  logic sched_valid, sched_sop, busy, cfg_error;
  logic [L-1:0] sched_flow_id;
  logic [31:0] grant_cnt, stall_cnt;
  ccip_tx_flow_scheduler #(
    .LMAX_NUM_OF_FLOWS(L), .LTX_FIFO_DEPTH(D), .LMAX_CCIP_BATCH(LB), .ALMFULL_HOLDOFF(HO)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .number_of_flows(nof), .l_tx_batch_size(bsz),
    .flow_dw(flow_dw), .sRx_c1TxAlmFull(alm), .pop_en(pop_en), .sched_valid(sched_valid),
    .sched_sop(sched_sop), .sched_flow_id(sched_flow_id), .busy(busy), .cfg_error(cfg_error),
    .grant_cnt(grant_cnt), .stall_cnt(stall_cnt)
  );
  always #5 clk = ~clk;
  typedef struct {int flow; bit sop;} beat_t;
  beat_t q[$];
  beat_t cur;
  int n_assert = 0, n_fail = 0;
  int ec, free_at, low_run, rr, grants, stalls;
  bit hold, cfg, ev;
  task automatic chk(input string tag, input logic [63:0] o, input logic [63:0] e);
    n_assert++;
    assert (o === e) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, o, e);
    end
  endtask
  function automatic int batch_of(input int b);
    return b == 0 ? 1 : (b == 1 ? 2 : 4);
  endfunction
  function automatic bit elig(input int i);
    return i <= int'(nof) && int'((flow_dw >> (i * D)) & 12'd7) >= batch_of(int'(bsz));
  endfunction
  function automatic int pick();
    int r, idx;
    r = rr > int'(nof) ? 0 : rr;
    for (int k = 0; k <= int'(nof); k++) begin
      idx = (r + k) % (int'(nof) + 1);
      if (elig(idx)) return idx;
    end
    return -1;
  endfunction
  task automatic set_dw(input int a, input int b, input int c, input int d);
    flow_dw = {3'(d), 3'(c), 3'(b), 3'(a)};
  endtask
  task automatic step();
    int w, nb;
    bit eb;
    @(posedge clk);
    if (!reset) begin
      q.delete();
      ec = 0; free_at = 0; hold = 0; low_run = 0; rr = 0; cfg = 0; grants = 0; stalls = 0;
    end else begin
      ec++;
      if (bsz == 2'd3) cfg = 1;
      w = pick();
      if (hold) begin
        if (w >= 0) stalls++;
        low_run = alm ? 0 : low_run + 1;
        if (low_run == HO) begin
          hold = 0;
          low_run = 0;
        end
      end else if (ec >= free_at) begin
        if (alm) begin
          hold = 1;
          low_run = 0;
        end else if (start && w >= 0) begin
          nb = batch_of(int'(bsz));
          for (int b = 0; b < nb; b++) q.push_back('{w, b == 0});
          free_at = ec + nb + 1;
          grants++;
          rr = (w == int'(nof)) ? 0 : w + 1;
        end
      end
    end
    ev = q.size() > 0;
    if (ev) cur = q.pop_front();
    eb = hold || (ec < free_at - 1);
    @(negedge clk);
    chk("pop_en", pop_en, ev ? (N'(1) << cur.flow) : '0);
    chk("sched_valid", sched_valid, ev);
    chk("sched_sop", sched_sop, ev && cur.sop);
    if (ev) chk("sched_flow_id", sched_flow_id, cur.flow);
    chk("busy", busy, eb);
    chk("grant_cnt", grant_cnt, grants);
    chk("stall_cnt", stall_cnt, stalls);
    chk("cfg_error", cfg_error, cfg);
  endtask
  task automatic wait_sop(input string tag);
    int c;
    c = 0;
    while (!sched_sop && c < 20) begin
      step();
      c++;
    end
    chk(tag, sched_sop, 1);
  endtask
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
  initial begin
    int nsop, g2, nb, beats, sops;
    int sop_flow[5], sop_at[5], exp_seq[5];
    logic [31:0] s0;
    exp_seq = '{0, 1, 2, 3, 0};
    nof = 2'd3; bsz = 2'd1; set_dw(0, 0, 0, 0);
    repeat (2) step();
    reset = 1'b1;
    flow_dw = {4{3'd2}};
    start = 1'b1;
    nsop = 0;
    for (int c = 0; c < 60 && nsop < 5; c++) begin
      step();
      if (sched_sop) begin
        sop_flow[nsop] = int'(sched_flow_id);
        sop_at[nsop] = c;
        nsop++;
      end
    end
    start = 1'b0;
    chk("t2_grants_seen", nsop, 5);
    for (int k = 0; k < nsop; k++) chk("t2_grant_order", sop_flow[k], exp_seq[k]);
    for (int k = 1; k < nsop; k++) chk("t2_start_spacing", sop_at[k] - sop_at[k-1], 3);
    repeat (4) step();
    chk("t2_grant_cnt", grant_cnt, 5);
    nof = 2'd0; bsz = 2'd2; set_dw(4, 0, 0, 0); start = 1'b1;
    wait_sop("t1_sop");
    step();
    chk("t1_beat2_valid", sched_valid, 1);
    reset = 1'b0;
    #1;
    chk("t1_async_pop_en", pop_en, 0);
    chk("t1_async_valid", sched_valid, 0);
    chk("t1_async_busy", busy, 0);
    chk("t1_async_grant_cnt", grant_cnt, 0);
    step();
    reset = 1'b1; start = 1'b0;
    step();
    chk("t1_idle_after_reset", busy, 0);
    nof = 2'd3; bsz = 2'd0; set_dw(7, 7, 7, 7); start = 1'b1;
    step();
    chk("t1_rr_zero_valid", sched_valid, 1);
    chk("t1_rr_zero_flow", sched_flow_id, 0);
    start = 1'b0;
    repeat (3) step();
    nof = 2'd3; bsz = 2'd1; set_dw(0, 1, 4, 0); start = 1'b1;
    g2 = 0;
    repeat (12) begin
      step();
      if (sched_valid) begin
        chk("t3_only_flow2", sched_flow_id, 2);
        g2++;
      end
    end
    chk("t3_flow2_granted", g2 != 0, 1);
    start = 1'b0;
    repeat (4) step();
    nof = 2'd0; bsz = 2'd2; set_dw(4, 0, 0, 0); start = 1'b1;
    wait_sop("t4_sop");
    step();
    alm = 1'b1;
    nb = 2;
    for (int c = 0; c < 10; c++) begin
      step();
      if (!sched_valid) break;
      nb++;
    end
    chk("t4_batch_completes", nb, 4);
    step();
    s0 = stall_cnt;
    repeat (5) step();
    chk("t4_stall_5", stall_cnt - s0, 5);
    alm = 1'b0;
    step();
    chk("t4_hold_cycle1_busy", busy, 1);
    step();
    chk("t4_hold_exit_busy", busy, 0);
    step();
    chk("t4_resume_valid", sched_valid, 1);
    start = 1'b0;
    repeat (6) step();
    nof = 2'd3; bsz = 2'd0; set_dw(7, 7, 7, 7);
    repeat (4) begin
      step();
      chk("t5_no_pop", pop_en, 0);
      chk("t5_not_busy", busy, 0);
    end
    start = 1'b1;
    step();
    chk("t5_grant_next_cycle", sched_valid, 1);
    start = 1'b0;
    repeat (3) step();
    bsz = 2'd3; nof = 2'd0; set_dw(4, 7, 0, 0); start = 1'b1;
    beats = 0; sops = 0;
    for (int c = 0; c < 22; c++) begin
      if (c == 16) start = 1'b0;
      step();
      if (sched_valid) begin
        beats++;
        chk("t6_only_flow0", sched_flow_id, 0);
      end
      if (sched_sop) sops++;
    end
    chk("t6_cfg_error", cfg_error, 1);
    chk("t6_batches_seen", sops >= 2, 1);
    chk("t6_four_beats_each", beats, 4 * sops);
    bsz = 2'd0;
    step();
    chk("t6_cfg_error_sticky", cfg_error, 1);
    repeat (500) begin
      if ($urandom % 4 == 0) flow_dw = (N*D)'($urandom);
      if ($urandom % 6 == 0) alm = ~alm;
      if ($urandom % 8 == 0) nof = L'($urandom);
      if ($urandom % 8 == 0) bsz = LB'($urandom_range(0, 3));
      start = ($urandom % 5) != 0;
      reset = ($urandom % 150) != 0;
      step();
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
